c17_bist_controller: RTL and testbench

- Built-in self-test driver and observer for the c17 combinational benchmark netlist.
- Drives the five primary inputs (N1, N2, N3, N6, N7) from a 5-bit maximal-length LFSR.
- Compacts the two primary outputs (N22, N23) into a MISR and compares the final signature against a golden value.
- Sits beside the synthesized CUT in the test wrapper and is the stimulus/response end of the CUT's I/O interface.

---
 rtl/c17_bist_controller.sv | 138 +++++++++++++
 tb/tb_c17_bist_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/c17_bist_controller.sv
// BIST driver/observer for the c17 benchmark: a 5-bit LFSR feeds the CUT inputs and
// an 8-bit MISR compacts N22/N23 into a signature checked against GOLDEN_SIG.
module c17_bist_controller #(
    parameter int                   PATTERN_COUNT = 31,
    parameter logic [4:0]           LFSR_SEED     = 5'h01,
    parameter int                   SIG_WIDTH     = 8,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG    = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_WIDTH-1:0] signature,
    output logic                 N1,
    output logic                 N2,
    output logic                 N3,
    output logic                 N6,
    output logic                 N7,
    input  logic                 N22,
    input  logic                 N23
);

    localparam logic [4:0]           LAST_CNT  = 5'(PATTERN_COUNT - 1);
    localparam logic [SIG_WIDTH-1:0] MISR_POLY = SIG_WIDTH'(8'h1D);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           lfsr_q, lfsr_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [SIG_WIDTH-1:0] misr_q, misr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    logic [4:0]           lfsr_next;
    logic [SIG_WIDTH-1:0] misr_next;

    assign lfsr_next = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    assign misr_next = {misr_q[SIG_WIDTH-2:0], 1'b0}
                     ^ (misr_q[SIG_WIDTH-1] ? MISR_POLY : '0)
                     ^ {{(SIG_WIDTH-2){1'b0}}, N23, N22};

    // start is a single-cycle request with no ready: it is only looked at in IDLE
    // and DONE, so a pulse while busy is simply dropped.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        misr_d  = misr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                lfsr_d  = LFSR_SEED;
                misr_d  = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                misr_d = misr_next;
                // The last pattern stays on the N pins through COMPARE and DONE.
                if (cnt_q == LAST_CNT) begin
                    state_d = COMPARE;
                end else begin
                    lfsr_d = lfsr_next;
                    cnt_d  = cnt_q + 5'd1;
                end
            end
            COMPARE: begin
                pass_d  = (misr_q == GOLDEN_SIG);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            misr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            misr_q  <= misr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;
    assign N1        = lfsr_q[0];
    assign N2        = lfsr_q[1];
    assign N3        = lfsr_q[2];
    assign N6        = lfsr_q[3];
    assign N7        = lfsr_q[4];

endmodule

// File: tb/tb_c17_bist_controller.sv
// Bench for c17_bist_controller: a zero-response CUT, a behavioural c17 with optional
// N22 stuck-at-0, and a single-pattern build, all driven from one clock and reset.
module tb_c17_bist_controller;

    function automatic logic [7:0] c17_sig(input logic stuck);
        logic [4:0] p;
        logic [7:0] m;
        logic n10, n11, n16, n19, n22, n23;
        p = 5'h01;
        m = 8'h00;
        for (int i = 0; i < 31; i++) begin
            n10 = ~(p[0] & p[2]);
            n11 = ~(p[2] & p[3]);
            n16 = ~(p[1] & n11);
            n19 = ~(n11 & p[4]);
            n22 = stuck ? 1'b0 : ~(n10 & n16);
            n23 = ~(n16 & n19);
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {6'b0, n23, n22};
            p = {p[3:0], p[4] ^ p[2]};
        end
        return m;
    endfunction

    localparam logic [7:0] GOLD       = c17_sig(1'b0);
    localparam logic [7:0] STUCK_SIG  = c17_sig(1'b1);

    logic clk, rst_n;
    logic start_z, start_c, start_o, stuck;

    logic       busy_z, done_z, pass_z;
    logic [7:0] sig_z;
    logic [4:0] pat_z;
    logic       busy_c, done_c, pass_c;
    logic [7:0] sig_c;
    logic [4:0] pat_c;
    logic       busy_o, done_o, pass_o;
    logic [7:0] sig_o;
    logic [4:0] pat_o;
    logic       n10, n11, n16, n19, n22_c, n23_c;

    int nvec = 0;
    int nmis = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    c17_bist_controller #(.PATTERN_COUNT(31), .LFSR_SEED(5'h01), .SIG_WIDTH(8), .GOLDEN_SIG(8'h00)) u_zero (
        .clk(clk), .rst_n(rst_n), .start(start_z), .busy(busy_z), .done(done_z), .pass(pass_z),
        .signature(sig_z), .N1(pat_z[0]), .N2(pat_z[1]), .N3(pat_z[2]), .N6(pat_z[3]), .N7(pat_z[4]),
        .N22(1'b0), .N23(1'b0));

    c17_bist_controller #(.PATTERN_COUNT(31), .LFSR_SEED(5'h01), .SIG_WIDTH(8), .GOLDEN_SIG(GOLD)) u_c17 (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .signature(sig_c), .N1(pat_c[0]), .N2(pat_c[1]), .N3(pat_c[2]), .N6(pat_c[3]), .N7(pat_c[4]),
        .N22(n22_c), .N23(n23_c));

    c17_bist_controller #(.PATTERN_COUNT(1), .LFSR_SEED(5'h01), .SIG_WIDTH(8), .GOLDEN_SIG(8'h00)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start_o), .busy(busy_o), .done(done_o), .pass(pass_o),
        .signature(sig_o), .N1(pat_o[0]), .N2(pat_o[1]), .N3(pat_o[2]), .N6(pat_o[3]), .N7(pat_o[4]),
        .N22(1'b0), .N23(1'b0));

    // Behavioural c17 netlist beside u_c17, with an N22 stuck-at-0 injection point.
    assign n10   = ~(pat_c[0] & pat_c[2]);
    assign n11   = ~(pat_c[2] & pat_c[3]);
    assign n16   = ~(pat_c[1] & n11);
    assign n19   = ~(n11 & pat_c[4]);
    assign n22_c = stuck ? 1'b0 : ~(n10 & n16);
    assign n23_c = ~(n16 & n19);

    typedef struct {
        int         cyc;
        logic       busy;
        logic       done;
        logic [4:0] pat;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_c17(output int lat);
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        lat = 0;
        while (!done_c && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int         lat;
        int         k;
        int         distinct;
        logic [31:0] seen;

        vecs[0] = '{0,  1'b1, 1'b0, 5'h00};
        vecs[1] = '{1,  1'b1, 1'b0, 5'h01};
        vecs[2] = '{2,  1'b1, 1'b0, 5'h02};
        vecs[3] = '{3,  1'b1, 1'b0, 5'h04};
        vecs[4] = '{4,  1'b1, 1'b0, 5'h09};
        vecs[5] = '{5,  1'b1, 1'b0, 5'h12};
        vecs[6] = '{6,  1'b1, 1'b0, 5'h05};
        vecs[7] = '{31, 1'b1, 1'b0, 5'h10};
        vecs[8] = '{32, 1'b1, 1'b0, 5'h10};
        vecs[9] = '{33, 1'b0, 1'b1, 5'h10};

        rst_n   = 1'b0;
        start_z = 1'b0;
        start_c = 1'b0;
        start_o = 1'b0;
        stuck   = 1'b0;
        tick();
        tick();
        check("reset_outputs_zero", {busy_z, done_z, pass_z, sig_z, pat_z}, '0);
        check("reset_outputs_c17", {busy_c, done_c, pass_c, sig_c, pat_c}, '0);
        check("reset_outputs_one", {busy_o, done_o, pass_o, sig_o, pat_o}, '0);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", {busy_z, done_z, pat_z}, '0);

        // Full zero-response run walked against the vector table.
        start_z = 1'b1;
        tick();
        start_z = 1'b0;
        seen = '0;
        for (int c = 0; c <= 33; c++) begin
            if (c > 0) tick();
            foreach (vecs[i]) begin
                if (vecs[i].cyc == c) begin
                    check($sformatf("tbl_busy_c%0d", c), busy_z, vecs[i].busy);
                    check($sformatf("tbl_done_c%0d", c), done_z, vecs[i].done);
                    check($sformatf("tbl_pat_c%0d", c), pat_z, vecs[i].pat);
                end
            end
            if (c >= 1 && c <= 31) seen[pat_z] = 1'b1;
        end
        distinct = 0;
        for (int i = 1; i < 32; i++) if (seen[i]) distinct++;
        check("all_patterns_distinct", distinct, 31);
        check("zero_pattern_never", seen[0], 1'b0);
        check("zero_sig", sig_z, 8'h00);
        check("zero_pass", pass_z, 1'b1);
        tick();
        check("done_held", {done_z, pass_z}, 2'b11);

        // Single-pattern build.
        start_o = 1'b1;
        tick();
        start_o = 1'b0;
        check("one_c0_busy", busy_o, 1'b1);
        tick();
        check("one_c1_pat", {busy_o, done_o, pat_o}, {1'b1, 1'b0, 5'h01});
        tick();
        check("one_c2_pat", {busy_o, done_o, pat_o}, {1'b1, 1'b0, 5'h01});
        tick();
        check("one_c3_done", {busy_o, done_o, pass_o, pat_o}, {1'b0, 1'b1, 1'b1, 5'h01});

        // start pulsed mid-RUN must not restart the run.
        start_z = 1'b1;
        tick();
        start_z = 1'b0;
        k = 0;
        while (!done_z && k < 60) begin
            start_z = (k == 4);
            tick();
            k++;
        end
        start_z = 1'b0;
        check("start_in_run_latency", k, 33);

        // Reset mid-run on the c17 instance.
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int c = 1; c <= 10; c++) tick();
        check("c17_busy_before_reset", busy_c, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {busy_c, done_c, sig_c, pat_c}, '0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("after_reset_idle", {busy_c, done_c, sig_c, pat_c}, '0);

        run_c17(lat);
        check("c17_latency", lat, 33);
        check("c17_sig", sig_c, GOLD);
        check("c17_pass", pass_c, 1'b1);

        stuck = 1'b1;
        run_c17(lat);
        check("stuck_latency", lat, 33);
        check("stuck_sig", sig_c, STUCK_SIG);
        check("stuck_pass", pass_c, 1'b0);
        stuck = 1'b0;

        // start held high: back-to-back runs with one DONE cycle between them.
        start_c = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            lat = 0;
            while (!done_c && lat < 60) begin
                tick();
                lat++;
            end
            check($sformatf("held_r%0d_latency", r), lat, 33);
            check($sformatf("held_r%0d_sig", r), sig_c, GOLD);
            check($sformatf("held_r%0d_pass", r), pass_c, 1'b1);
            tick();
            check($sformatf("held_r%0d_done_one_cycle", r), {done_c, busy_c, pass_c}, 3'b010);
        end
        start_c = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
